count_seq_ctrl: RTL and testbench



---
 rtl/count_seq_pkg.sv | 34 +++
 rtl/step_counter.sv | 51 +++++
 rtl/count_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_count_seq_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_seq_pkg.sv
// Shared definitions for the count sequencer: FSM state type, default widths and
// the advance rule used by the step counter.
package count_seq_pkg;

    localparam int unsigned DefW  = 3;
    localparam int unsigned DefLW = 4;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } state_e;

    // Advance rule on a counter of 'width' bits. A value at or above the limit wraps to 0.
    // A sum that no longer fits in 'width' bits also wraps to 0.
    function automatic logic [31:0] next_count(input logic [31:0] cur,
                                               input logic [31:0] step,
                                               input logic [31:0] limit,
                                               input int unsigned width);
        logic [32:0] sum;
        logic [32:0] max_val;
        max_val = (33'd1 << width) - 33'd1;
        sum     = {1'b0, cur} + {1'b0, step};
        if (cur >= limit) begin
            return '0;
        end
        if (sum > max_val) begin
            return '0;
        end
        return sum[31:0];
    endfunction

endpackage

// File: rtl/step_counter.sv
// Registered W-bit step-modulo counter.
// Ports:
//   clk   - rising-edge clock
//   rst   - synchronous active-low reset (out -> 0)
//   en    - apply one advance this edge
//   clr   - force out to 0 this edge (wins over en)
//   step  - increment per advance
//   limit - wrap threshold
//   out   - registered count value
module step_counter
    import count_seq_pkg::*;
#(
    parameter int unsigned W = DefW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] step,
    input  logic [W-1:0] limit,
    output logic [W-1:0] out
);

    logic [W-1:0] out_q;
    logic [W-1:0] out_d;
    logic [31:0]  nxt;
    logic         unused_nxt;

    assign nxt        = next_count(32'(out_q), 32'(step), 32'(limit), W);
    assign unused_nxt = ^nxt[31:W];

    always_comb begin
        out_d = out_q;
        if (clr) begin
            out_d = '0;
        end else if (en) begin
            out_d = nxt[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/count_seq_ctrl.sv
// Sequencer for the step-modulo counter: latches a configuration through a
// valid/ready handshake, then runs the counter for exactly cfg_len advances,
// with pause/resume and abort.
// Ports:
//   clk, rst                      - clock, synchronous active-low reset
//   cfg_valid/cfg_ready           - configuration handshake (ready in IDLE/DONE)
//   cfg_step, cfg_limit, cfg_len  - step, wrap threshold, number of advances
//   start                         - begin a run with the latched configuration
//   pause                         - level; holds the count during a run
//   abort                         - end the run, back to IDLE, count kept
//   out                           - registered count value
//   busy                          - high in RUN or PAUSE
//   done                          - one-cycle pulse after the final advance
module count_seq_ctrl
    import count_seq_pkg::*;
#(
    parameter int unsigned W  = DefW,
    parameter int unsigned LW = DefLW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [W-1:0]  cfg_step,
    input  logic [W-1:0]  cfg_limit,
    input  logic [LW-1:0] cfg_len,
    input  logic          start,
    input  logic          pause,
    input  logic          abort,
    output logic [W-1:0]  out,
    output logic          busy,
    output logic          done
);

    state_e        state_q, state_d;
    logic [W-1:0]  step_q, step_d;
    logic [W-1:0]  limit_q, limit_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] rem_q, rem_d;
    logic          done_q, done_d;
    logic          cnt_en;
    logic          cnt_clr;
    logic          cfg_xfer;

    assign cfg_ready = (state_q == StIdle) || (state_q == StDone);
    assign busy      = (state_q == StRun) || (state_q == StPause);
    assign done      = done_q;
    assign cfg_xfer  = cfg_valid && cfg_ready;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        limit_d = limit_q;
        len_d   = len_q;
        rem_d   = rem_q;
        done_d  = 1'b0;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;

        // Only possible in IDLE/DONE; a new config restarts the count from 0.
        if (cfg_xfer) begin
            step_d  = cfg_step;
            limit_d = cfg_limit;
            len_d   = cfg_len;
            cnt_clr = 1'b1;
        end

        unique case (state_q)
            StIdle, StDone: begin
                // A run always starts from the previously latched length.
                if (start && (len_q != '0)) begin
                    state_d = StRun;
                    rem_d   = len_q;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (pause) begin
                    state_d = StPause;
                end else begin
                    cnt_en = 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == LW'(1)) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                    end
                end
            end
            StPause: begin
                // Leaving PAUSE costs one edge with no advance.
                if (abort) begin
                    state_d = StIdle;
                end else if (!pause) begin
                    state_d = StRun;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StIdle;
            step_q  <= '0;
            limit_q <= '0;
            len_q   <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            limit_q <= limit_d;
            len_q   <= len_d;
            rem_q   <= rem_d;
            done_q  <= done_d;
        end
    end

    step_counter #(
        .W(W)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .en   (cnt_en),
        .clr  (cnt_clr),
        .step (step_q),
        .limit(limit_q),
        .out  (out)
    );

endmodule

// File: tb/tb_count_seq_ctrl.sv
module tb_count_seq_ctrl;

    localparam int W  = 3;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [W-1:0]  cfg_step;
    logic [W-1:0]  cfg_limit;
    logic [LW-1:0] cfg_len;
    logic          start;
    logic          pause;
    logic          abort;
    logic [W-1:0]  out;
    logic          busy;
    logic          done;

    int n_run  = 0;
    int n_fail = 0;

    // Reference model: run bookkeeping in terms of advances left.
    int m_out, m_step, m_limit, m_len, m_left;
    bit m_run, m_pause, m_done;

    always #5 clk = ~clk;

    count_seq_ctrl #(
        .W (W),
        .LW(LW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_step (cfg_step),
        .cfg_limit(cfg_limit),
        .cfg_len  (cfg_len),
        .start    (start),
        .pause    (pause),
        .abort    (abort),
        .out      (out),
        .busy     (busy),
        .done     (done)
    );

    function automatic int advance(int o, int st, int lim);
        if (o >= lim) return 0;
        if (o + st > (1 << W) - 1) return 0;
        return o + st;
    endfunction

    // Update the model with the inputs about to be sampled, then cross the edge.
    task automatic clk_edge();
        bit xfer;
        if (!rst) begin
            m_out = 0; m_step = 0; m_limit = 0; m_len = 0; m_left = 0;
            m_run = 0; m_pause = 0; m_done = 0;
        end else begin
            xfer   = cfg_valid && !m_run;
            m_done = 0;
            if (m_run) begin
                if (abort) begin
                    m_run = 0; m_pause = 0;
                end else if (m_pause) begin
                    if (!pause) m_pause = 0;
                end else if (pause) begin
                    m_pause = 1;
                end else begin
                    m_out  = advance(m_out, m_step, m_limit);
                    m_left = m_left - 1;
                    if (m_left == 0) begin
                        m_run = 0; m_done = 1;
                    end
                end
            end else begin
                if (start && m_len != 0) begin
                    m_run = 1; m_left = m_len;
                end
                if (xfer) begin
                    m_step = int'(cfg_step); m_limit = int'(cfg_limit); m_len = int'(cfg_len);
                    m_out  = 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(int s, int l, int n);
        cfg_valid = 1'b1;
        cfg_step  = W'(s);
        cfg_limit = W'(l);
        cfg_len   = LW'(n);
        clk_edge();
        cfg_valid = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        clk_edge();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clk_edge();
        clk_edge();
        rst = 1'b1;
        n_run++;
        if (out !== '0) begin n_fail++; $display("FAIL reset_out got %0d want 0", out); end
        n_run++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_run++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
        n_run++;
        if (cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_cfg_ready got %b want 1", cfg_ready);
        end
    endtask

    task automatic test_basic();
        int exp_seq[8] = '{2, 4, 6, 0, 2, 4, 6, 0};
        int busy_cycles = 0;
        set_cfg(2, 6, 8);
        kick();
        for (int i = 0; i < 8; i++) begin
            if (busy === 1'b1) busy_cycles++;
            n_run++;
            if (done !== 1'b0) begin n_fail++; $display("FAIL basic_early_done step %0d", i); end
            clk_edge();
            n_run++;
            if (out !== W'(exp_seq[i]) || out !== W'(m_out)) begin
                n_fail++;
                $display("FAIL basic_out step %0d got %0d want %0d", i, out, exp_seq[i]);
            end
        end
        n_run++;
        if (busy_cycles != 8) begin
            n_fail++; $display("FAIL basic_busy_cycles got %0d want 8", busy_cycles);
        end
        n_run++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_done got done=%b busy=%b want 1/0", done, busy);
        end
        clk_edge();
        n_run++;
        if (done !== 1'b0 || out !== '0) begin
            n_fail++; $display("FAIL basic_hold got done=%b out=%0d want 0/0", done, out);
        end
    endtask

    task automatic test_pause();
        set_cfg(1, 7, 5);
        kick();
        clk_edge();
        clk_edge();
        n_run++;
        if (out !== 3'd2) begin n_fail++; $display("FAIL pause_pre got %0d want 2", out); end
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_edge();
            n_run++;
            if (out !== 3'd2 || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL pause_hold cyc %0d got out=%0d busy=%b want 2/1", i, out, busy);
            end
        end
        pause = 1'b0;
        clk_edge();
        n_run++;
        if (out !== 3'd2) begin n_fail++; $display("FAIL pause_bubble got %0d want 2", out); end
        for (int v = 3; v <= 5; v++) begin
            clk_edge();
            n_run++;
            if (out !== W'(v) || out !== W'(m_out)) begin
                n_fail++; $display("FAIL pause_resume got %0d want %0d", out, v);
            end
        end
        n_run++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL pause_done got %b want 1", done); end
        clk_edge();
        n_run++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL pause_done_len got %b want 0", done); end
    endtask

    task automatic test_overflow();
        int exp_seq[4] = '{3, 6, 0, 3};
        set_cfg(3, 7, 4);
        kick();
        for (int i = 0; i < 4; i++) begin
            clk_edge();
            n_run++;
            if (out !== W'(exp_seq[i]) || out !== W'(m_out)) begin
                n_fail++;
                $display("FAIL overflow_out step %0d got %0d want %0d", i, out, exp_seq[i]);
            end
        end
        n_run++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL overflow_done got %b want 1", done); end
    endtask

    task automatic test_abort_handshake();
        int done_seen = 0;
        set_cfg(2, 7, 6);
        kick();
        clk_edge();
        clk_edge();
        abort = 1'b1;
        clk_edge();
        abort = 1'b0;
        n_run++;
        if (out !== 3'd4 || busy !== 1'b0 || cfg_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_state got out=%0d busy=%b rdy=%b done=%b want 4/0/1/0",
                     out, busy, cfg_ready, done);
        end
        for (int i = 0; i < 3; i++) begin
            clk_edge();
            if (done === 1'b1) done_seen++;
        end
        n_run++;
        if (done_seen != 0 || out !== 3'd4) begin
            n_fail++; $display("FAIL abort_no_done got pulses=%0d out=%0d want 0/4", done_seen, out);
        end
        kick();
        cfg_valid = 1'b1;
        cfg_step  = 3'd1;
        cfg_limit = 3'd3;
        cfg_len   = 4'd2;
        n_run++;
        if (cfg_ready !== 1'b0) begin
            n_fail++; $display("FAIL run_cfg_ready got %b want 0", cfg_ready);
        end
        for (int i = 0; i < 6; i++) begin
            clk_edge();
            cfg_valid = 1'b0;
            n_run++;
            if (out !== W'(m_out)) begin
                n_fail++; $display("FAIL run_cfg_ignored step %0d got %0d want %0d", i, out, m_out);
            end
        end
        n_run++;
        if (done !== 1'b1 || out !== 3'd0) begin
            n_fail++; $display("FAIL run_cfg_done got done=%b out=%0d want 1/0", done, out);
        end
    endtask

    task automatic test_zero();
        set_cfg(3, 7, 0);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            clk_edge();
            n_run++;
            if (busy !== 1'b0 || out !== '0) begin
                n_fail++; $display("FAIL zero_len got busy=%b out=%0d want 0/0", busy, out);
            end
        end
        start = 1'b0;
        set_cfg(0, 5, 3);
        kick();
        for (int i = 0; i < 3; i++) begin
            n_run++;
            if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_step_busy got %b want 1", busy); end
            clk_edge();
            n_run++;
            if (out !== '0) begin n_fail++; $display("FAIL zero_step_out got %0d want 0", out); end
        end
        n_run++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL zero_step_done got %b want 1", done); end
    endtask

    task automatic test_reset_midrun();
        set_cfg(1, 7, 6);
        kick();
        for (int i = 0; i < 4; i++) clk_edge();
        n_run++;
        if (out !== 3'd4) begin n_fail++; $display("FAIL midrun_pre got %0d want 4", out); end
        rst = 1'b0;
        clk_edge();
        rst = 1'b1;
        n_run++;
        if (out !== '0 || busy !== 1'b0 || cfg_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset got out=%0d busy=%b rdy=%b want 0/0/1", out, busy, cfg_ready);
        end
        kick();
        n_run++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrun_len_cleared got %b want 0", busy); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(99) >= 2);
            cfg_valid = ($urandom_range(99) < 20);
            cfg_step  = W'($urandom);
            cfg_limit = W'($urandom);
            cfg_len   = LW'($urandom_range(6));
            start     = ($urandom_range(99) < 30);
            pause     = ($urandom_range(99) < 20);
            abort     = ($urandom_range(99) < 4);
            clk_edge();
            n_run++;
            if (out !== W'(m_out) || busy !== m_run || done !== m_done || cfg_ready !== !m_run) begin
                n_fail++;
                $display("FAIL random cyc %0d got out=%0d busy=%b done=%b rdy=%b want %0d/%b/%b/%b",
                         i, out, busy, done, cfg_ready, m_out, m_run, m_done, !m_run);
            end
        end
        rst = 1'b1; cfg_valid = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        cfg_valid = 1'b0;
        cfg_step  = '0;
        cfg_limit = '0;
        cfg_len   = '0;
        start     = 1'b0;
        pause     = 1'b0;
        abort     = 1'b0;
        test_reset();
        test_basic();
        test_pause();
        test_overflow();
        test_abort_handshake();
        test_zero();
        test_reset_midrun();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
